// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Interrupt entry/return sequencer for the 5-stage pipeline.
// Rising edges on the request lines are latched into a pending set. The lowest
// enabled pending source is taken at a safe boundary. Taking it means one cycle
// of redirect to that source's vector, with IF/ID and ID/EX flushed. The resume
// address and the cause are saved. An mret in EX while the handler runs
// redirects back to the saved EPC. Nesting is not supported.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_irq          request lines, a rising edge is a request
//   i_irq_en       per-source enable mask (1 = may be taken)
//   i_stall        load-use stall; holds entry/return pulses back
//   i_redirect     branch/jump redirect happening this cycle
//   i_redirect_pc  target of that redirect
//   i_resume_pc    PC of the oldest instruction in ID
//   i_mret_ex      valid, unflushed mret in EX
//   o_int_sig      1-cycle pulse: next PC = o_int_pc (vector)
//   o_ret_sig      1-cycle pulse: next PC = o_int_pc (EPC)
//   o_int_pc       redirect target for either pulse, 0 otherwise
//   o_flush        flush IF/ID and ID/EX (o_int_sig | o_ret_sig)
//   o_in_isr       handler active
//   o_irq_ack      one-hot acknowledge, same cycle as o_int_sig
//   o_epc          saved resume address
//   o_cause        index of the last taken source
// -----------------------------------------------------------------------------
module irq_controller #(
    parameter int          NUM_IRQ  = 4,
    parameter logic [31:0] VEC_BASE = 32'h0000_0080
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_en,
    input  logic               i_stall,
    input  logic               i_redirect,
    input  logic [31:0]        i_redirect_pc,
    input  logic [31:0]        i_resume_pc,
    input  logic               i_mret_ex,
    output logic               o_int_sig,
    output logic               o_ret_sig,
    output logic [31:0]        o_int_pc,
    output logic               o_flush,
    output logic               o_in_isr,
    output logic [NUM_IRQ-1:0] o_irq_ack,
    output logic [31:0]        o_epc,
    output logic [2:0]         o_cause
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TAKE = 2'd1,
        ST_ISR  = 2'd2,
        ST_RET  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_pending;
    logic [2:0]         r_sel;
    logic [31:0]        r_epc;
    logic [2:0]         r_cause;

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [2:0]         w_winner;
    logic               w_fire;
    logic               w_take_start;
    logic [31:0]        w_vec_pc;

    assign w_rise     = i_irq & ~r_irq_d;
    assign w_eligible = r_pending & i_irq_en;
    assign w_vec_pc   = VEC_BASE + {27'd0, r_sel, 2'b00};

    // Fixed priority: scanning downward leaves the lowest set index as winner.
    always_comb begin
        w_winner = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_winner = 3'(i);
            end
        end
    end

    // Acknowledge is tied to the cycle in which the entry pulse really fires,
    // so a stall in TAKE keeps the selected source pending.
    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
        assign o_irq_ack[gi] = w_fire & (r_sel == 3'(gi));
    end

    always_comb begin
        w_state_next = r_state;
        w_fire       = 1'b0;
        o_int_sig    = 1'b0;
        o_ret_sig    = 1'b0;
        o_int_pc     = 32'd0;
        o_in_isr     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Never start an entry alongside a redirect or stall, the
                // boundary would not be clean. mret here is ignored.
                if ((|w_eligible) && !i_redirect && !i_stall) begin
                    w_state_next = ST_TAKE;
                end
            end
            ST_TAKE: begin
                if (!i_stall) begin
                    w_fire       = 1'b1;
                    o_int_sig    = 1'b1;
                    o_int_pc     = w_vec_pc;
                    w_state_next = ST_ISR;
                end
            end
            ST_ISR: begin
                o_in_isr = 1'b1;
                if (i_mret_ex && !i_stall) begin
                    w_state_next = ST_RET;
                end
            end
            ST_RET: begin
                o_ret_sig    = 1'b1;
                o_int_pc     = r_epc;
                o_in_isr     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_take_start = (r_state == ST_IDLE) && (w_state_next == ST_TAKE);
    assign o_flush      = o_int_sig | o_ret_sig;
    assign o_epc        = r_epc;
    assign o_cause      = r_cause;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_irq_d   <= '0;
            r_pending <= '0;
            r_sel     <= 3'd0;
            r_epc     <= 32'd0;
            r_cause   <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_irq_d <= i_irq;
            // A fresh edge in the ack cycle re-arms the same source.
            r_pending <= (r_pending & ~o_irq_ack) | w_rise;
            if (w_take_start) begin
                r_sel <= w_winner;
            end
            if (w_fire) begin
                r_cause <= r_sel;
                // A branch resolving in the entry cycle owns the return point.
                r_epc <= i_redirect ? i_redirect_pc : i_resume_pc;
            end
        end
    end

endmodule
